// File: rtl/sun_pll_pkg.sv
// Shared types and constants for the SUN PLL lock controller.
package sun_pll_pkg;

  typedef enum logic [2:0] {
    ST_OFF,
    ST_SETTLE,
    ST_ACQ,
    ST_LOCK,
    ST_FAIL
  } pll_state_t;

  localparam int unsigned CNT_W     = 11;  // edge counter / FREQ_CNT width
  localparam int unsigned WIN_CNT_W = 10;  // window position counter, up to 1024 cycles
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam int unsigned GOOD_RUN  = 4;   // consecutive good windows to lock
  localparam int unsigned BAD_RUN   = 2;   // consecutive bad windows to unlock

  function automatic int unsigned abs_diff(input logic [CNT_W-1:0] cnt,
                                           input int unsigned ref_val);
    int unsigned c;
    c = 32'(cnt);
    return (c > ref_val) ? c - ref_val : ref_val - c;
  endfunction

endpackage

// File: rtl/sun_pll_fcnt.sv
// Feedback-toggle window counter: synchronizer, edge detect, per-window
// edge count and good/bad classification of the closing window.
module sun_pll_fcnt
  import sun_pll_pkg::*;
#(
  parameter int unsigned WIN_LEN    = 256,
  parameter int unsigned EXP_CNT    = 32,
  parameter int unsigned TOL_LOCK   = 1,
  parameter int unsigned TOL_UNLOCK = 3
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             run,
  input  logic             fb_tgl,
  output logic             win_end,
  output logic             win_good,
  output logic             win_bad,
  output logic [CNT_W-1:0] freq_cnt
);

  logic [2:0]           sync_q;
  logic                 fb_edge;
  logic [WIN_CNT_W-1:0] win_cnt;
  logic [CNT_W-1:0]     edge_cnt;
  logic [CNT_W-1:0]     cnt_next;
  int unsigned          err_abs;

  assign fb_edge = sync_q[2] ^ sync_q[1];

  // Classification uses cnt_next so an edge in the closing cycle is counted.
  always_comb begin
    cnt_next = edge_cnt;
    if (fb_edge && (edge_cnt != CNT_MAX)) cnt_next = edge_cnt + CNT_W'(1);
    err_abs  = abs_diff(cnt_next, EXP_CNT);
    win_end  = run && (win_cnt == WIN_CNT_W'(WIN_LEN - 1));
    win_good = (err_abs <= TOL_LOCK);
    win_bad  = (err_abs > TOL_UNLOCK);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      sync_q   <= '0;
      win_cnt  <= '0;
      edge_cnt <= '0;
      freq_cnt <= '0;
    end else begin
      sync_q <= {sync_q[1:0], fb_tgl};
      if (!run) begin
        win_cnt  <= '0;
        edge_cnt <= '0;
      end else if (win_end) begin
        freq_cnt <= cnt_next;
        win_cnt  <= '0;
        edge_cnt <= '0;
      end else begin
        win_cnt  <= win_cnt + WIN_CNT_W'(1);
        edge_cnt <= cnt_next;
      end
    end
  end

endmodule

// File: rtl/sun_pll_ctrl.sv
// SUN PLL power-up / frequency-lock controller: settle, acquire, lock,
// timeout; outputs registered from the next state.
module sun_pll_ctrl
  import sun_pll_pkg::*;
#(
  parameter int unsigned WIN_LEN    = 256,
  parameter int unsigned EXP_CNT    = 32,
  parameter int unsigned TOL_LOCK   = 1,
  parameter int unsigned TOL_UNLOCK = 3,
  parameter int unsigned SETTLE     = 64,
  parameter int unsigned MAX_WIN    = 64
) (
  input  logic             CK_REF,
  input  logic             RSTN,
  input  logic             EN,
  input  logic             FB_TGL,
  output logic             PWRUP_1V8,
  output logic             LOCKED,
  output logic             CK_EN,
  output logic             ERR,
  output logic [CNT_W-1:0] FREQ_CNT
);

  localparam int unsigned SET_W = $clog2(SETTLE + 1);
  localparam int unsigned WN_W  = $clog2(MAX_WIN + 1);

  pll_state_t       state_q, state_d;
  logic [SET_W-1:0] settle_q, settle_d;
  logic [WN_W-1:0]  nwin_q, nwin_d;
  logic [2:0]       good_q, good_d;
  logic             bad_q, bad_d;
  logic             pwrup_d, lock_d, err_d;
  logic             run, win_end, win_good, win_bad;

  assign run   = (state_q == ST_ACQ) || (state_q == ST_LOCK);
  assign CK_EN = LOCKED;

  sun_pll_fcnt #(
    .WIN_LEN   (WIN_LEN),
    .EXP_CNT   (EXP_CNT),
    .TOL_LOCK  (TOL_LOCK),
    .TOL_UNLOCK(TOL_UNLOCK)
  ) u_fcnt (
    .clk     (CK_REF),
    .rstn    (RSTN),
    .run     (run),
    .fb_tgl  (FB_TGL),
    .win_end (win_end),
    .win_good(win_good),
    .win_bad (win_bad),
    .freq_cnt(FREQ_CNT)
  );

  always_comb begin
    state_d  = state_q;
    settle_d = '0;
    nwin_d   = nwin_q;
    good_d   = good_q;
    bad_d    = bad_q;
    if (!EN) begin
      state_d = ST_OFF;
      nwin_d  = '0;
      good_d  = '0;
      bad_d   = 1'b0;
    end else begin
      unique case (state_q)
        ST_OFF:    state_d = ST_SETTLE;
        ST_SETTLE: begin
          if (settle_q == SET_W'(SETTLE - 1)) begin
            state_d = ST_ACQ;
            nwin_d  = '0;
            good_d  = '0;
          end else begin
            settle_d = settle_q + SET_W'(1);
          end
        end
        ST_ACQ: begin
          if (win_end) begin
            nwin_d = nwin_q + WN_W'(1);
            good_d = win_good ? good_q + 3'd1 : 3'd0;
            // A window completing the good streak locks even if it is also the last allowed.
            if (win_good && (good_q == 3'(GOOD_RUN - 1))) begin
              state_d = ST_LOCK;
              good_d  = '0;
              bad_d   = 1'b0;
            end else if (nwin_q == WN_W'(MAX_WIN - 1)) begin
              state_d = ST_FAIL;
            end
          end
        end
        ST_LOCK: begin
          if (win_end) begin
            if (!win_bad) begin
              bad_d = 1'b0;
            end else if (bad_q) begin
              state_d = ST_ACQ;
              bad_d   = 1'b0;
              good_d  = '0;
              nwin_d  = '0;
            end else begin
              bad_d = 1'b1;
            end
          end
        end
        ST_FAIL:   state_d = ST_FAIL;
        default:   state_d = ST_OFF;
      endcase
    end
    pwrup_d = (state_d == ST_SETTLE) || (state_d == ST_ACQ) || (state_d == ST_LOCK);
    lock_d  = (state_d == ST_LOCK);
    err_d   = (state_d == ST_FAIL);
  end

  always_ff @(posedge CK_REF) begin
    if (!RSTN) begin
      state_q   <= ST_OFF;
      settle_q  <= '0;
      nwin_q    <= '0;
      good_q    <= '0;
      bad_q     <= 1'b0;
      PWRUP_1V8 <= 1'b0;
      LOCKED    <= 1'b0;
      ERR       <= 1'b0;
    end else begin
      state_q   <= state_d;
      settle_q  <= settle_d;
      nwin_q    <= nwin_d;
      good_q    <= good_d;
      bad_q     <= bad_d;
      PWRUP_1V8 <= pwrup_d;
      LOCKED    <= lock_d;
      ERR       <= err_d;
    end
  end

endmodule

// File: tb/tb_sun_pll_ctrl.sv
// Self-checking bench for sun_pll_ctrl: table-driven lock/unlock sequence,
// hand-written corner sequences and a randomized run against a window-level model.
module tb_sun_pll_ctrl;

  localparam int WIN  = 256;
  localparam int EXPC = 32;
  localparam int STL  = 64;
  localparam int MAXW = 64;

  logic        CK_REF = 1'b0;
  logic        RSTN, EN, FB_TGL;
  logic        PWRUP_1V8, LOCKED, CK_EN, ERR;
  logic [10:0] FREQ_CNT;

  sun_pll_ctrl #(
    .WIN_LEN(WIN), .EXP_CNT(EXPC), .TOL_LOCK(1), .TOL_UNLOCK(3),
    .SETTLE(STL), .MAX_WIN(MAXW)
  ) dut (
    .CK_REF(CK_REF), .RSTN(RSTN), .EN(EN), .FB_TGL(FB_TGL),
    .PWRUP_1V8(PWRUP_1V8), .LOCKED(LOCKED), .CK_EN(CK_EN), .ERR(ERR),
    .FREQ_CNT(FREQ_CNT)
  );

  always #5 CK_REF = ~CK_REF;

  // cyc = number of rising edges so far; fb_hist[k] = FB_TGL sampled at edge k
  int cyc = 0;
  bit fb_hist [0:131071];
  always @(posedge CK_REF) begin
    fb_hist[cyc] <= FB_TGL;
    cyc          <= cyc + 1;
  end

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // FB stimulus: 0 static, 1 evenly spaced pat[w] toggles, 2 random placement
  int mode  = 0;
  int pat_s = 0;
  int pat[$];
  int rnd_need, rnd_slots;

  task automatic next_cycle();
    int k, rel, off, n;
    @(negedge CK_REF);
    k   = cyc;
    rel = k - (pat_s - 1);
    if (mode != 0 && rel >= 0) begin
      off = rel % WIN;
      if (mode == 1) begin
        if (rel / WIN < pat.size()) begin
          n = pat[rel / WIN];
          if (((off + 1) * n + WIN - 1) / WIN != (off * n + WIN - 1) / WIN) FB_TGL = ~FB_TGL;
        end
      end else begin
        if (off == 0) begin
          rnd_need  = ($urandom_range(9) < 7) ? int'($urandom_range(33, 31))
                                              : int'($urandom_range(40, 24));
          rnd_slots = WIN;
        end
        if (int'($urandom_range(rnd_slots - 1)) < rnd_need) begin
          FB_TGL = ~FB_TGL;
          rnd_need--;
        end
        rnd_slots--;
      end
    end
  endtask

  task automatic goto_cycle(input int target);
    while (cyc < target) next_cycle();
  endtask

  // EN rises; measurement windows start SETTLE edges after the sampling edge
  task automatic arm(input int m);
    EN    = 1'b1;
    pat_s = cyc + STL;
    mode  = m;
    next_cycle();
    chk("pwrup_rise", PWRUP_1V8, 1);
    chk("locked_at_rise", LOCKED, 0);
  endtask

  function automatic int win_count(input int s, input int w);
    int c = 0;
    for (int k = s + w * WIN; k < s + (w + 1) * WIN; k++) c += int'(fb_hist[k-1] ^ fb_hist[k-2]);
    return (c > 2047) ? 2047 : c;
  endfunction

  // window-level lock qualification model
  bit m_lock, m_fail;
  int m_streak, m_bad, m_nwin;

  task automatic model_window(input int c);
    int d;
    d = (c > EXPC) ? c - EXPC : EXPC - c;
    if (m_fail) return;
    if (!m_lock) begin
      m_nwin++;
      m_streak = (d <= 1) ? m_streak + 1 : 0;
      if (m_streak == 4) begin
        m_lock = 1; m_streak = 0; m_bad = 0;
      end else if (m_nwin == MAXW) begin
        m_fail = 1;
      end
    end else begin
      m_bad = (d > 3) ? m_bad + 1 : 0;
      if (m_bad == 2) begin
        m_lock = 0; m_bad = 0; m_nwin = 0; m_streak = 0;
      end
    end
  endtask

  task automatic run_fixed(input int s, input int nw, input int cnt, input int lock_at);
    for (int w = 0; w < nw; w++) begin
      goto_cycle(s + (w + 1) * WIN + 1);
      chk("fix_freq", FREQ_CNT, cnt);
      chk("fix_locked", LOCKED, (w >= lock_at) ? 1 : 0);
    end
  endtask

  typedef struct { int edges; int exp_cnt; bit exp_lock; } vec_t;
  vec_t tab [21];

  initial begin
    int s;
    tab[0]  = '{32, 32, 0}; tab[1]  = '{32, 32, 0}; tab[2]  = '{32, 32, 0};
    tab[3]  = '{32, 32, 1}; tab[4]  = '{36, 36, 1}; tab[5]  = '{32, 32, 1};
    tab[6]  = '{36, 36, 1}; tab[7]  = '{36, 36, 0}; tab[8]  = '{33, 33, 0};
    tab[9]  = '{31, 31, 0}; tab[10] = '{34, 34, 0}; tab[11] = '{32, 32, 0};
    tab[12] = '{32, 32, 0}; tab[13] = '{32, 32, 0}; tab[14] = '{32, 32, 1};
    tab[15] = '{35, 35, 1}; tab[16] = '{29, 29, 1}; tab[17] = '{28, 28, 1};
    tab[18] = '{32, 32, 1}; tab[19] = '{28, 28, 1}; tab[20] = '{256, 256, 0};

    RSTN = 1'b0; EN = 1'b0; FB_TGL = 1'b0;
    repeat (3) next_cycle();
    chk("rst_pwrup", PWRUP_1V8, 0);
    chk("rst_locked", LOCKED, 0);
    chk("rst_ck_en", CK_EN, 0);
    chk("rst_err", ERR, 0);
    chk("rst_freq", FREQ_CNT, 0);
    RSTN = 1'b1;
    repeat (2) next_cycle();
    chk("off_idle_pwrup", PWRUP_1V8, 0);

    // lock, single/double bad windows, streak reset, tolerance edges
    pat.delete();
    foreach (tab[i]) pat.push_back(tab[i].edges);
    arm(1);
    s = pat_s;
    for (int w = 0; w < 21; w++) begin
      goto_cycle(s + (w + 1) * WIN);
      chk("tab_lock_before", LOCKED, (w == 0) ? 1'b0 : tab[w-1].exp_lock);
      next_cycle();
      chk("tab_freq", FREQ_CNT, tab[w].exp_cnt);
      chk("tab_locked", LOCKED, tab[w].exp_lock);
      chk("tab_ck_en", CK_EN, tab[w].exp_lock);
      chk("tab_err", ERR, 0);
      chk("tab_pwrup", PWRUP_1V8, 1);
    end
    EN = 1'b0;
    next_cycle();
    chk("off_pwrup", PWRUP_1V8, 0);
    chk("off_locked", LOCKED, 0);
    chk("off_freq_held", FREQ_CNT, 256);

    // EN dropped during settle: nothing measured
    repeat (3) next_cycle();
    pat.delete();
    repeat (3) pat.push_back(32);
    arm(1);
    repeat (10) next_cycle();
    EN = 1'b0;
    next_cycle();
    chk("settle_drop_pwrup", PWRUP_1V8, 0);
    goto_cycle(cyc + STL + 2 * WIN);
    chk("settle_drop_freq", FREQ_CNT, 256);
    chk("settle_drop_locked", LOCKED, 0);

    // reset while locked, then relock from settle
    pat.delete();
    repeat (6) pat.push_back(32);
    arm(1);
    run_fixed(pat_s, 4, 32, 3);
    goto_cycle(cyc + 100);
    RSTN = 1'b0;
    next_cycle();
    chk("mid_rst_pwrup", PWRUP_1V8, 0);
    chk("mid_rst_locked", LOCKED, 0);
    chk("mid_rst_ck_en", CK_EN, 0);
    chk("mid_rst_err", ERR, 0);
    chk("mid_rst_freq", FREQ_CNT, 0);
    RSTN = 1'b1;
    pat.delete();
    repeat (6) pat.push_back(32);
    arm(1);
    run_fixed(pat_s, 4, 32, 3);

    // static feedback: acquisition timeout
    EN = 1'b0;
    repeat (3) next_cycle();
    arm(0);
    s = pat_s;
    for (int w = 0; w < MAXW; w++) begin
      goto_cycle(s + (w + 1) * WIN + 1);
      chk("to_freq", FREQ_CNT, 0);
      chk("to_err", ERR, (w == MAXW - 1) ? 1 : 0);
      chk("to_pwrup", PWRUP_1V8, (w == MAXW - 1) ? 0 : 1);
    end
    goto_cycle(cyc + 3 * WIN);
    chk("fail_hold_err", ERR, 1);
    chk("fail_hold_pwrup", PWRUP_1V8, 0);
    EN = 1'b0;
    next_cycle();
    chk("fail_clear_err", ERR, 0);
    chk("fail_clear_pwrup", PWRUP_1V8, 0);

    // randomized window counts against the window-level model
    repeat (3) next_cycle();
    m_lock = 0; m_fail = 0; m_streak = 0; m_bad = 0; m_nwin = 0;
    arm(2);
    s = pat_s;
    for (int w = 0; w < 40; w++) begin
      int c;
      goto_cycle(s + (w + 1) * WIN + 1);
      c = win_count(s, w);
      model_window(c);
      if (!m_fail || m_nwin == MAXW) chk("rnd_freq", FREQ_CNT, c);
      chk("rnd_locked", LOCKED, m_lock);
      chk("rnd_ck_en", CK_EN, m_lock);
      chk("rnd_err", ERR, m_fail);
      chk("rnd_pwrup", PWRUP_1V8, !m_fail);
      if (m_fail) break;
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
